skid_flop: RTL and testbench



---
 rtl/skid_flop.sv | 88 ++++++++
 tb/tb_skid_flop.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/skid_flop.sv
// Two-entry registered valid/ready stage: main register feeds out_data, skid register
// absorbs one extra word so in_ready can be a flop instead of a function of out_ready.
module skid_flop #(
  parameter int size = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [size-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [size-1:0] out_data,
  input  logic            out_ready,
  output logic [1:0]      occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [size-1:0] main_reg, main_next;
  logic [size-1:0] skid_reg, skid_next;
  logic            in_ready_reg, out_valid_reg;
  logic [1:0]      occ_reg;
  logic            in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          main_next  = in_data;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (in_fire) begin
          skid_next  = in_data;
          state_next = TWO;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_next  = skid_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Handshake outputs are flopped from the next state so they never depend on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      occ_reg       <= 2'd0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      in_ready_reg  <= (state_next != TWO);
      out_valid_reg <= (state_next != EMPTY);
      occ_reg       <= state_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = main_reg;
  assign occ       = occ_reg;

endmodule

// File: tb/tb_skid_flop.sv
// Directed and random checks of skid_flop at size=4 and size=1.
module tb_skid_flop;

  logic       clk;
  logic       rst_n;
  logic       iv4, or4, ir4, ov4;
  logic [3:0] id4, od4;
  logic [1:0] occ4;
  logic       iv1, or1, ir1, ov1;
  logic [0:0] id1, od1;
  logic [1:0] occ1;

  int tests_run;
  int tests_failed;

  logic [3:0] q4[$];
  logic       q1[$];

  skid_flop #(.size(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_ready(or4), .occ(occ4)
  );

  skid_flop #(.size(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_data(id1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(or1), .occ(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the four observable outputs of the size=4 instance and logs the transaction.
  task automatic expect4(input string tag, input logic ov, input logic [3:0] od,
                         input logic ir, input logic [1:0] oc);
    $display("[TB] %s: ov=%0d od=%0h ir=%0d occ=%0d", tag, ov4, od4, ir4, occ4);
    chk({tag, ".out_valid"}, 32'(ov4), 32'(ov));
    chk({tag, ".out_data"},  32'(od4), 32'(od));
    chk({tag, ".in_ready"},  32'(ir4), 32'(ir));
    chk({tag, ".occ"},       32'(occ4), 32'(oc));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; id4 = 4'h0;
    iv1 = 1'b0; or1 = 1'b0; id1 = 1'b0;

    #12;
    expect4("reset", 1'b0, 4'h0, 1'b1, 2'd0);
    chk("reset1.out_valid", 32'(ov1), 32'd0);
    chk("reset1.in_ready", 32'(ir1), 32'd1);
    chk("reset1.occ", 32'(occ1), 32'd0);
    rst_n = 1'b1;
    #1;

    // Streaming
    or4 = 1'b1; iv4 = 1'b1;
    id4 = 4'h1; tick(); expect4("stream1", 1'b1, 4'h1, 1'b1, 2'd1);
    id4 = 4'h2; tick(); expect4("stream2", 1'b1, 4'h2, 1'b1, 2'd1);
    id4 = 4'h3; tick(); expect4("stream3", 1'b1, 4'h3, 1'b1, 2'd1);
    id4 = 4'h4; tick(); expect4("stream4", 1'b1, 4'h4, 1'b1, 2'd1);
    iv4 = 1'b0; tick(); expect4("stream_end", 1'b0, 4'h4, 1'b1, 2'd0);

    // Empty boundary: out_ready while empty does nothing
    tick(); expect4("empty_ready", 1'b0, 4'h4, 1'b1, 2'd0);

    // Fill and stall
    or4 = 1'b0; iv4 = 1'b1;
    id4 = 4'h7; tick(); expect4("fill1", 1'b1, 4'h7, 1'b1, 2'd1);
    id4 = 4'h8; tick(); expect4("fill2", 1'b1, 4'h7, 1'b0, 2'd2);
    id4 = 4'h9;
    for (int i = 0; i < 3; i++) begin
      tick(); expect4("stall", 1'b1, 4'h7, 1'b0, 2'd2);
    end

    // Drain from full; 4'h9 must never appear
    iv4 = 1'b0; or4 = 1'b1;
    tick(); expect4("drain1", 1'b1, 4'h8, 1'b1, 2'd1);
    tick(); expect4("drain2", 1'b0, 4'h8, 1'b1, 2'd0);

    // Simultaneous accept and drain in ONE
    or4 = 1'b0; iv4 = 1'b1; id4 = 4'hC;
    tick(); expect4("sim_load", 1'b1, 4'hC, 1'b1, 2'd1);
    id4 = 4'hD; or4 = 1'b1;
    tick(); expect4("sim_both", 1'b1, 4'hD, 1'b1, 2'd1);
    iv4 = 1'b0;
    tick(); expect4("sim_drain", 1'b0, 4'hD, 1'b1, 2'd0);

    // Reset mid-stream from TWO
    or4 = 1'b0; iv4 = 1'b1; id4 = 4'h3;
    tick();
    id4 = 4'h5;
    tick(); expect4("pre_reset", 1'b1, 4'h3, 1'b0, 2'd2);
    iv4 = 1'b0;
    #2 rst_n = 1'b0;
    #1 expect4("async_reset", 1'b0, 4'h0, 1'b1, 2'd0);
    #1 rst_n = 1'b1;
    iv4 = 1'b1; id4 = 4'hA;
    tick(); expect4("post_reset", 1'b1, 4'hA, 1'b1, 2'd1);
    iv4 = 1'b0; or4 = 1'b1;
    tick(); expect4("post_drain", 1'b0, 4'hA, 1'b1, 2'd0);

    // Random valid/ready against an ideal two-deep FIFO, both widths at once
    q4.delete();
    q1.delete();
    for (int c = 0; c < 2000; c++) begin
      logic f_in4, f_out4, f_in1, f_out1;
      iv4 = 1'($urandom_range(0, 1));
      or4 = 1'($urandom_range(0, 1));
      id4 = 4'($urandom);
      iv1 = 1'($urandom_range(0, 1));
      or1 = 1'($urandom_range(0, 1));
      id1 = 1'($urandom);
      f_in4  = iv4 && (q4.size() < 2);
      f_out4 = or4 && (q4.size() > 0);
      f_in1  = iv1 && (q1.size() < 2);
      f_out1 = or1 && (q1.size() > 0);
      if (f_out4) void'(q4.pop_front());
      if (f_in4) q4.push_back(id4);
      if (f_out1) void'(q1.pop_front());
      if (f_in1) q1.push_back(id1);
      tick();
      chk("rnd4.occ", 32'(occ4), 32'(q4.size()));
      chk("rnd4.out_valid", 32'(ov4), 32'(q4.size() != 0));
      chk("rnd4.in_ready", 32'(ir4), 32'(q4.size() != 2));
      if (q4.size() != 0) chk("rnd4.out_data", 32'(od4), 32'(q4[0]));
      chk("rnd1.occ", 32'(occ1), 32'(q1.size()));
      chk("rnd1.out_valid", 32'(ov1), 32'(q1.size() != 0));
      chk("rnd1.in_ready", 32'(ir1), 32'(q1.size() != 2));
      if (q1.size() != 0) chk("rnd1.out_data", 32'(od1), 32'(q1[0]));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
